// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: writeback request, scoreboard and register-file write bundle
interface rf_wb_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int ADSize = 5,
    parameter int DASize = 32
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*ADSize-1:0]   req_addr;
    logic [NREQ*DASize-1:0]   req_data;
    logic                     hold;
    logic                     issue_valid;
    logic [ADSize-1:0]        issue_rd;
    logic                     flush;
    logic                     rf_write;
    logic [ADSize-1:0]        rf_waddr;
    logic [DASize-1:0]        rf_wdata;
    logic [(1<<ADSize)-1:0]   busy;
    modport master (
        output req_valid, req_addr, req_data, hold, issue_valid, issue_rd, flush,
        input  req_ready, rf_write, rf_waddr, rf_wdata, busy
    );
    modport slave (
        input  req_valid, req_addr, req_data, hold, issue_valid, issue_rd, flush,
        output req_ready, rf_write, rf_waddr, rf_wdata, busy
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin writeback arbiter with busy scoreboard; WB_FIXED_PRIO_EN selects fixed priority
module rf_wb_arbiter #(
    parameter int NREQ   = 3,
    parameter int ADSize = 5,
    parameter int DASize = 32
) (
    input logic           clk,
    input logic           rst,
    rf_wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    logic [PW-1:0]            g;
    logic                     found;
    logic                     xfer;
    logic                     wr;
    logic [ADSize-1:0]        gaddr;
    logic [DASize-1:0]        gdata;
    logic [(1<<ADSize)-1:0]   busy_nxt;
`ifdef WB_FIXED_PRIO_EN
    // lowest valid index wins
    always_comb begin
        g = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (bus.req_valid[PW'(k)]) begin
                g = PW'(k);
                found = 1'b1;
            end
    end
`else
    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    // first valid index at or above ptr, wrapping modulo NREQ
    always_comb begin
        g = '0;
        found = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (bus.req_valid[idx]) begin
                g = idx;
                found = 1'b1;
            end
        end
    end
    // advance the pointer past the requester just served
    always_ff @(posedge clk or posedge rst)
        if (rst) ptr <= '0;
        else if (xfer) ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
`endif
    assign xfer = found & ~bus.hold;
    assign bus.req_ready = xfer ? (NREQ'(1) << g) : '0;
    assign gaddr = bus.req_addr[g*ADSize +: ADSize];
    assign gdata = bus.req_data[g*DASize +: DASize];
    assign wr = xfer && gaddr != '0;
    // flush clears, writeback clears its target, a new issue sets and wins; x0 never busy
    always_comb begin
        busy_nxt = bus.flush ? '0 : bus.busy;
        if (wr) busy_nxt[gaddr] = 1'b0;
        if (bus.issue_valid) busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end
    // registered write port and scoreboard
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            bus.rf_write <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.busy     <= '0;
        end else begin
            bus.rf_write <= wr;
            if (wr) begin
                bus.rf_waddr <= gaddr;
                bus.rf_wdata <= gdata;
            end
            bus.busy <= busy_nxt;
        end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed and randomized check of rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;
    localparam int NREQ = 3;
    localparam int ADS  = 5;
    localparam int DAS  = 32;
    localparam int NB   = 1 << ADS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.NREQ(NREQ), .ADSize(ADS), .DASize(DAS)) bus();
    rf_wb_arbiter #(.NREQ(NREQ), .ADSize(ADS), .DASize(DAS)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model state
    int              m_ptr = 0;
    logic            m_write = 1'b0;
    logic [ADS-1:0]  m_waddr = '0;
    logic [DAS-1:0]  m_wdata = '0;
    logic [NB-1:0]   m_busy = '0;

    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    function automatic int grant_now();
        if (bus.hold) return -1;
`ifdef WB_FIXED_PRIO_EN
        return pick(bus.req_valid, 0);
`else
        return pick(bus.req_valid, m_ptr);
`endif
    endfunction

    function automatic logic [ADS-1:0] addr_of(input int i);
        return bus.req_addr[i*ADS +: ADS];
    endfunction

    function automatic logic [DAS-1:0] data_of(input int i);
        return bus.req_data[i*DAS +: DAS];
    endfunction

    function automatic logic writes_now();
        return grant_now() >= 0 && addr_of(grant_now()) != '0;
    endfunction

    function automatic logic [NB-1:0] busy_next();
        logic [NB-1:0] b;
        b = bus.flush ? '0 : m_busy;
        if (writes_now()) b[addr_of(grant_now())] = 1'b0;
        if (bus.issue_valid && bus.issue_rd != '0) b[bus.issue_rd] = 1'b1;
        return b;
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) begin
            m_ptr   <= 0;
            m_write <= 1'b0;
            m_waddr <= '0;
            m_wdata <= '0;
            m_busy  <= '0;
        end else begin
            m_busy  <= busy_next();
            m_write <= writes_now();
            if (writes_now()) begin
                m_waddr <= addr_of(grant_now());
                m_wdata <= data_of(grant_now());
            end
`ifndef WB_FIXED_PRIO_EN
            if (grant_now() >= 0) m_ptr <= (grant_now() + 1) % NREQ;
`endif
        end

    // compare every cycle, mid-period
    always @(negedge clk) begin
        chk("req_ready", 64'(bus.req_ready), grant_now() < 0 ? 64'd0 : 64'd1 << grant_now());
        chk("rf_write", 64'(bus.rf_write), 64'(m_write));
        chk("rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
        chk("rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
        chk("busy", 64'(bus.busy), 64'(m_busy));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    logic [NREQ-1:0] gr;
    logic [63:0]     rr_exp;

    initial begin
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        bus.hold = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_rd = '0;
        bus.flush = 1'b0;
        @(posedge clk);
        #2;
        chk("rst_write", 64'(bus.rf_write), 64'd0);
        chk("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        // single request
        bus.req_valid = 3'b001;
        bus.req_addr = 15'd5;
        bus.req_data = {64'd0, 32'hDEADBEEF};
        #1 chk("single_ready", 64'(bus.req_ready), 64'd1);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("single_write", 64'(bus.rf_write), 64'd1);
        chk("single_waddr", 64'(bus.rf_waddr), 64'd5);
        chk("single_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        cyc();
        #1 chk("single_write_off", 64'(bus.rf_write), 64'd0);
        // all requesters valid continuously
        reset_pulse();
        bus.req_valid = 3'b111;
        bus.req_addr = {5'd3, 5'd2, 5'd1};
        bus.req_data = {32'd300, 32'd200, 32'd100};
        for (int c = 0; c < 6; c++) begin
`ifdef WB_FIXED_PRIO_EN
            rr_exp = 64'd1;
`else
            rr_exp = 64'd1 << (c % 3);
`endif
            #1 chk($sformatf("rr_grant%0d", c), 64'(bus.req_ready), rr_exp);
            cyc();
        end
        bus.req_valid = '0;
        // scoreboard set then clear
        reset_pulse();
        bus.issue_valid = 1'b1;
        bus.issue_rd = 5'd7;
        cyc();
        bus.issue_valid = 1'b0;
        #1 chk("sb_set7", 64'(bus.busy[7]), 64'd1);
        cyc();
        cyc();
        bus.req_valid = 3'b001;
        bus.req_addr = 15'd7;
        #1 chk("sb_hold7", 64'(bus.busy[7]), 64'd1);
        cyc();
        bus.req_valid = '0;
        #1;
        chk("sb_clr7", 64'(bus.busy[7]), 64'd0);
        chk("sb_clr7_write", 64'(bus.rf_waddr), 64'd7);
        // set and clear of the same register together
        bus.issue_valid = 1'b1;
        cyc();
        bus.req_valid = 3'b001;
        cyc();
        bus.issue_valid = 1'b0;
        bus.req_valid = '0;
        #1;
        chk("sb_setwins", 64'(bus.busy[7]), 64'd1);
        chk("sb_setwins_write", 64'(bus.rf_write), 64'd1);
        // x0 handling
        reset_pulse();
        bus.issue_valid = 1'b1;
        bus.issue_rd = 5'd0;
        cyc();
        bus.issue_valid = 1'b0;
        #1 chk("x0_issue", 64'(bus.busy), 64'd0);
        bus.req_valid = 3'b001;
        bus.req_addr = 15'd0;
        #1 chk("x0_ready", 64'(bus.req_ready), 64'd1);
        cyc();
        bus.req_valid = '0;
        #1 chk("x0_nowrite", 64'(bus.rf_write), 64'd0);
        // hold freezes grants and pointer
        bus.hold = 1'b1;
        bus.req_valid = 3'b111;
        bus.req_addr = {5'd3, 5'd2, 5'd1};
        #1 chk("hold_ready0", 64'(bus.req_ready), 64'd0);
        cyc();
        #1 chk("hold_ready1", 64'(bus.req_ready), 64'd0);
        cyc();
        bus.hold = 1'b0;
`ifdef WB_FIXED_PRIO_EN
        #1 chk("hold_release", 64'(bus.req_ready), 64'd1);
`else
        #1 chk("hold_release", 64'(bus.req_ready), 64'd2);
`endif
        bus.req_valid = '0;
        cyc();
        // flush with a simultaneous issue
        reset_pulse();
        bus.issue_valid = 1'b1;
        bus.issue_rd = 5'd3;
        cyc();
        bus.issue_rd = 5'd9;
        cyc();
        bus.issue_valid = 1'b0;
        #1 chk("flush_pre", 64'(bus.busy), 64'h208);
        bus.flush = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_rd = 5'd12;
        cyc();
        bus.flush = 1'b0;
        bus.issue_valid = 1'b0;
        #1 chk("flush_post", 64'(bus.busy), 64'h1000);
        // asynchronous reset mid-stream
        bus.req_valid = 3'b001;
        bus.req_addr = 15'd4;
        bus.req_data = {64'd0, 32'h12345678};
        bus.issue_valid = 1'b1;
        bus.issue_rd = 5'd6;
        cyc();
        bus.req_valid = '0;
        bus.issue_valid = 1'b0;
        #1;
        chk("arst_pre_write", 64'(bus.rf_write), 64'd1);
        chk("arst_pre_busy", 64'(bus.busy), 64'h1040);
        rst = 1'b1;
        #1;
        chk("arst_write", 64'(bus.rf_write), 64'd0);
        chk("arst_waddr", 64'(bus.rf_waddr), 64'd0);
        chk("arst_wdata", 64'(bus.rf_wdata), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        cyc();
        rst = 1'b0;
        // randomized traffic; requesters keep their request stable until granted
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gr = bus.req_ready & bus.req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++)
                if (!bus.req_valid[i] || gr[i]) begin
                    bus.req_valid[i] = $urandom_range(0, 99) < 60;
                    bus.req_addr[i*ADS +: ADS] = ($urandom_range(0, 7) == 0) ? '0 : ADS'($urandom);
                    bus.req_data[i*DAS +: DAS] = $urandom;
                end
            bus.hold = $urandom_range(0, 9) == 0;
            bus.issue_valid = $urandom_range(0, 1) == 1;
            bus.issue_rd = ADS'($urandom);
            bus.flush = $urandom_range(0, 19) == 0;
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
